cmd_frame_parser: RTL and testbench

Framed serial-command decoder between the UART byte receiver and the flight-control state machine. It consumes one received byte per `rx_valid` strobe and assembles fixed-header, length-prefixed, checksummed frames. It publishes the decoded action code and two 16-bit target parameters, and supervises the link, forcing a failsafe action when no valid frame arrives in time.

---
 rtl/cmd_frame_parser_if.sv | 23 ++
 rtl/cmd_frame_parser.sv | 134 +++++++++++++
 tb/tb_cmd_frame_parser.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_parser_if.sv
// Byte-in / decoded-command-out bundle between the UART receiver, the frame
// parser and the flight-control consumer.
interface cmd_frame_parser_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [7:0]  action;
   logic [15:0] param0;
   logic [15:0] param1;
   logic        frame_valid;
   logic        chk_err;
   logic        frame_err;
   logic        link_ok;

   modport master (
      output rx_valid, rx_data,
      input  action, param0, param1, frame_valid, chk_err, frame_err, link_ok
   );

   modport slave (
      input  rx_valid, rx_data,
      output action, param0, param1, frame_valid, chk_err, frame_err, link_ok
   );
endinterface

// File: rtl/cmd_frame_parser.sv
// Decodes AA 55 CMD LEN payload CHK frames into action/param latches and
// supervises byte and link timing. rst_n is asynchronous and active-high.
module cmd_frame_parser #(
   parameter int unsigned MAX_LEN          = 4,
   parameter int unsigned BYTE_TIMEOUT_CYC = 50000,
   parameter int unsigned LINK_TIMEOUT_CYC = 25000000,
   parameter logic [7:0]  FAILSAFE_ACTION  = 8'h02
) (
   input logic               clk,
   input logic               rst_n,
   cmd_frame_parser_if.slave bus
);
   localparam int unsigned BW = $clog2(BYTE_TIMEOUT_CYC + 1);
   localparam int unsigned LW = $clog2(LINK_TIMEOUT_CYC + 1);

   // state   | meaning
   // HDR0    | hunting for 0xAA
   // HDR1    | got 0xAA, expecting 0x55
   // CMD     | next byte is the command code
   // LEN     | next byte is the payload length
   // PAYLOAD | collecting payload bytes into the shadow buffer
   // CHK     | next byte is the checksum
   typedef enum logic [2:0] {
      S_HDR0, S_HDR1, S_CMD, S_LEN, S_PAYLOAD, S_CHK
   } state_t;

   state_t        state;
   logic [7:0]    cmd_q;
   logic [7:0]    len_q;
   logic [7:0]    cnt_q;
   logic [7:0]    sum_q;
   logic [31:0]   shadow;
   logic [BW-1:0] byte_tmr;
   logic [LW-1:0] link_tmr;
   logic          commit;
   logic          byte_to;

   assign commit  = (state == S_CHK) && bus.rx_valid && (bus.rx_data == sum_q);
   assign byte_to = (state != S_HDR0) && !bus.rx_valid &&
                    (byte_tmr == BW'(BYTE_TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state           <= S_HDR0;
         cmd_q           <= '0;
         len_q           <= '0;
         cnt_q           <= '0;
         sum_q           <= '0;
         shadow          <= '0;
         byte_tmr        <= '0;
         link_tmr        <= '0;
         bus.action      <= '0;
         bus.param0      <= '0;
         bus.param1      <= '0;
         bus.frame_valid <= 1'b0;
         bus.chk_err     <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.link_ok     <= 1'b0;
      end else begin
         bus.frame_valid <= 1'b0;
         bus.chk_err     <= 1'b0;
         bus.frame_err   <= 1'b0;

         if (state == S_HDR0 || bus.rx_valid || byte_to) begin
            byte_tmr <= '0;
         end else begin
            byte_tmr <= byte_tmr + 1'b1;
         end

         if (bus.rx_valid) begin
            unique case (state)
               S_HDR0: begin
                  if (bus.rx_data == 8'hAA) state <= S_HDR1;
               end
               S_HDR1: begin
                  if (bus.rx_data == 8'h55)      state <= S_CMD;
                  else if (bus.rx_data != 8'hAA) state <= S_HDR0;
               end
               S_CMD: begin
                  cmd_q  <= bus.rx_data;
                  sum_q  <= bus.rx_data;
                  shadow <= '0;
                  state  <= S_LEN;
               end
               S_LEN: begin
                  len_q <= bus.rx_data;
                  sum_q <= sum_q + bus.rx_data;
                  cnt_q <= '0;
                  if (bus.rx_data > 8'(MAX_LEN)) begin
                     bus.frame_err <= 1'b1;
                     state         <= S_HDR0;
                  end else if (bus.rx_data == 8'd0) begin
                     state <= S_CHK;
                  end else begin
                     state <= S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  shadow[{cnt_q[1:0], 3'b000} +: 8] <= bus.rx_data;
                  sum_q <= sum_q + bus.rx_data;
                  cnt_q <= cnt_q + 8'd1;
                  if (cnt_q + 8'd1 == len_q) state <= S_CHK;
               end
               S_CHK: begin
                  if (!commit) bus.chk_err <= 1'b1;
                  state <= S_HDR0;
               end
               default: state <= S_HDR0;
            endcase
         end else if (byte_to) begin
            bus.frame_err <= 1'b1;
            state         <= S_HDR0;
         end

         // A commit in the expiry cycle takes priority over the failsafe.
         if (commit) begin
            link_tmr        <= '0;
            bus.link_ok     <= 1'b1;
            bus.frame_valid <= 1'b1;
            bus.action      <= cmd_q;
            bus.param0      <= {shadow[7:0], shadow[15:8]};
            bus.param1      <= {shadow[23:16], shadow[31:24]};
         end else if (link_tmr == LW'(LINK_TIMEOUT_CYC - 1)) begin
            link_tmr    <= LW'(LINK_TIMEOUT_CYC);
            bus.link_ok <= 1'b0;
            bus.action  <= FAILSAFE_ACTION;
            bus.param0  <= '0;
            bus.param1  <= '0;
         end else if (link_tmr != LW'(LINK_TIMEOUT_CYC)) begin
            link_tmr <= link_tmr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: directed frame table, timing corner sequences,
// and random byte streams against a frame-level reference model.
module tb_cmd_frame_parser;
   localparam int BTO  = 40;
   localparam int LTO  = 600;
   localparam int MAXL = 4;
   localparam logic [7:0] FS = 8'h02;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cmd_frame_parser_if bus();

   cmd_frame_parser #(
      .MAX_LEN(MAXL), .BYTE_TIMEOUT_CYC(BTO), .LINK_TIMEOUT_CYC(LTO), .FAILSAFE_ACTION(FS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0]  n;
      logic [79:0] b;
      logic [7:0]  act;
      logic [15:0] p0;
      logic [15:0] p1;
      logic [2:0]  pulse;
   } vec_t;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
   } cyc_t;

   vec_t vecs[10];
   cyc_t stim[$];

   // reference model state
   logic [7:0]  q[$];
   int          e, last_byte_e, last_commit_e;
   logic [7:0]  m_act;
   logic [15:0] m_p0, m_p1;
   logic        m_ok, m_fv, m_ce, m_fe;

   function automatic logic [43:0] snap();
      return {bus.action, bus.param0, bus.param1, bus.frame_valid, bus.chk_err, bus.frame_err, bus.link_ok};
   endfunction

   function automatic logic [43:0] pk(logic [7:0] a, logic [15:0] p0, logic [15:0] p1, logic [2:0] pl, logic ok);
      return {a, p0, p1, pl, ok};
   endfunction

   task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got {act,p0,p1,fv/ce/fe,ok}=%h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      bus.rx_valid = v;
      bus.rx_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [79:0] b, input int n);
      for (int i = 0; i < n; i++) step(1'b1, b[79-8*i -: 8]);
   endtask

   task automatic do_reset();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
   endtask

   task automatic model_reset();
      q.delete();
      e = 0; last_byte_e = 0; last_commit_e = 0;
      m_act = 8'h00; m_p0 = 16'h0; m_p1 = 16'h0; m_ok = 1'b0;
      m_fv = 1'b0; m_ce = 1'b0; m_fe = 1'b0;
   endtask

   // Frame-level view: q holds the bytes of the candidate frame collected so far.
   task automatic model_step(input logic v, input logic [7:0] d);
      logic       commit;
      int         s, len;
      logic [7:0] pl[4];
      e++;
      m_fv = 1'b0; m_ce = 1'b0; m_fe = 1'b0;
      commit = 1'b0;
      if (v) begin
         last_byte_e = e;
         if (q.size() == 0) begin
            if (d == 8'hAA) q.push_back(d);
         end else if (q.size() == 1) begin
            if (d == 8'h55) q.push_back(d);
            else if (d != 8'hAA) q.delete();
         end else begin
            q.push_back(d);
            if (q.size() == 4 && int'(q[3]) > MAXL) begin
               m_fe = 1'b1;
               q.delete();
            end else if (q.size() >= 5 && q.size() == 5 + int'(q[3])) begin
               s = 0;
               for (int i = 2; i < q.size() - 1; i++) s += int'(q[i]);
               if ((s % 256) == int'(q[q.size()-1])) begin
                  commit = 1'b1;
                  len = int'(q[3]);
                  for (int i = 0; i < 4; i++) pl[i] = (i < len) ? q[4+i] : 8'h00;
                  m_act = q[2];
                  m_p0 = {pl[0], pl[1]};
                  m_p1 = {pl[2], pl[3]};
                  m_fv = 1'b1;
                  m_ok = 1'b1;
                  last_commit_e = e;
               end else begin
                  m_ce = 1'b1;
               end
               q.delete();
            end
         end
      end else if (q.size() != 0 && e - last_byte_e == BTO) begin
         m_fe = 1'b1;
         q.delete();
      end
      if (!commit && e - last_commit_e == LTO) begin
         m_ok = 1'b0;
         m_act = FS;
         m_p0 = 16'h0;
         m_p1 = 16'h0;
      end
   endtask

   task automatic gen_byte(input logic [7:0] d);
      int gap;
      gap = ($urandom_range(0, 15) == 0) ? int'($urandom_range(BTO - 2, BTO)) : int'($urandom_range(0, 2));
      repeat (gap) stim.push_back({1'b0, 8'h00});
      stim.push_back({1'b1, d});
   endtask

   initial begin
      vecs[0] = '{n: 7, b: 80'hAA55_0302_01F4_FA00_0000, act: 8'h03, p0: 16'h01F4, p1: 16'h0000, pulse: 3'b100};
      vecs[1] = '{n: 5, b: 80'hAA55_0100_0000_0000_0000, act: 8'h03, p0: 16'h01F4, p1: 16'h0000, pulse: 3'b010};
      vecs[2] = '{n: 6, b: 80'hAAAA_5501_0001_0000_0000, act: 8'h01, p0: 16'h0000, p1: 16'h0000, pulse: 3'b100};
      vecs[3] = '{n: 4, b: 80'hAA55_0105_0000_0000_0000, act: 8'h01, p0: 16'h0000, p1: 16'h0000, pulse: 3'b001};
      vecs[4] = '{n: 9, b: 80'hAA55_0704_1234_FEDC_2B00, act: 8'h07, p0: 16'h1234, p1: 16'hFEDC, pulse: 3'b100};
      vecs[5] = '{n: 6, b: 80'hAA55_0501_8086_0000_0000, act: 8'h05, p0: 16'h8000, p1: 16'h0000, pulse: 3'b100};
      vecs[6] = '{n: 9, b: 80'h12AA_5509_0311_2233_7200, act: 8'h09, p0: 16'h1122, p1: 16'h3300, pulse: 3'b100};
      vecs[7] = '{n: 7, b: 80'hAA57_AA55_0B00_0B00_0000, act: 8'h0B, p0: 16'h0000, p1: 16'h0000, pulse: 3'b100};
      vecs[8] = '{n: 8, b: 80'hAA55_0C03_0102_0316_0000, act: 8'h0B, p0: 16'h0000, p1: 16'h0000, pulse: 3'b010};
      vecs[9] = '{n: 4, b: 80'hAA55_00FF_0000_0000_0000, act: 8'h0B, p0: 16'h0000, p1: 16'h0000, pulse: 3'b001};

      do_reset();
      check("reset_values", snap(), pk(8'h00, 16'h0, 16'h0, 3'b000, 1'b0));

      for (int i = 0; i < 10; i++) begin
         send(vecs[i].b, int'(vecs[i].n));
         check($sformatf("vec%0d", i), snap(), pk(vecs[i].act, vecs[i].p0, vecs[i].p1, vecs[i].pulse, 1'b1));
         step(1'b0, 8'h00);
         check($sformatf("vec%0d_pulse_end", i), snap(), pk(vecs[i].act, vecs[i].p0, vecs[i].p1, 3'b000, 1'b1));
      end

      // inter-byte timeout, then recovery
      send(80'hAA55_0302_0100_0000_0000, 5);
      repeat (BTO - 1) step(1'b0, 8'h00);
      check("byte_to_early", snap(), pk(8'h0B, 16'h0, 16'h0, 3'b000, 1'b1));
      step(1'b0, 8'h00);
      check("byte_to_fire", snap(), pk(8'h0B, 16'h0, 16'h0, 3'b001, 1'b1));
      send(80'hAA55_0400_0400_0000_0000, 5);
      check("after_timeout", snap(), pk(8'h04, 16'h0, 16'h0, 3'b100, 1'b1));

      // byte arriving in the timeout cycle wins
      send(80'hAA55_0000_0000_0000_0000, 2);
      repeat (BTO - 1) step(1'b0, 8'h00);
      send(80'h0600_0600_0000_0000_0000, 3);
      check("byte_wins", snap(), pk(8'h06, 16'h0, 16'h0, 3'b100, 1'b1));

      // commit landing in the link-expiry cycle
      repeat (LTO - 7) step(1'b0, 8'h00);
      send(80'hAA55_0102_1234_0000_0000, 6);
      check("link_pre_expiry", snap(), pk(8'h06, 16'h0, 16'h0, 3'b000, 1'b1));
      step(1'b1, 8'h49);
      check("commit_beats_expiry", snap(), pk(8'h01, 16'h1234, 16'h0, 3'b100, 1'b1));

      // link loss and restore
      repeat (LTO - 1) step(1'b0, 8'h00);
      check("link_still_ok", snap(), pk(8'h01, 16'h1234, 16'h0, 3'b000, 1'b1));
      step(1'b0, 8'h00);
      check("link_lost", snap(), pk(FS, 16'h0, 16'h0, 3'b000, 1'b0));
      send(vecs[0].b, 7);
      check("link_restored", snap(), pk(8'h03, 16'h01F4, 16'h0, 3'b100, 1'b1));

      // asynchronous reset mid-frame
      send(80'hAA55_0300_0000_0000_0000, 3);
      #2 rst_n = 1'b1;
      #1 check("async_reset", snap(), pk(8'h00, 16'h0, 16'h0, 3'b000, 1'b0));
      @(posedge clk);
      #1 rst_n = 1'b0;
      send(vecs[5].b, 6);
      check("after_reset_frame", snap(), pk(8'h05, 16'h8000, 16'h0, 3'b100, 1'b1));

      // random streams against the reference model
      stim.delete();
      for (int k = 0; k < 150; k++) begin
         int kind, len, sum, n;
         logic [7:0] c, x;
         kind = int'($urandom_range(0, 9));
         case (kind)
            0, 1, 2, 3, 4, 5: begin
               len = int'($urandom_range(0, MAXL));
               c = 8'($urandom);
               gen_byte(8'hAA); gen_byte(8'h55); gen_byte(c); gen_byte(8'(len));
               sum = int'(c) + len;
               for (int i = 0; i < len; i++) begin
                  x = 8'($urandom);
                  gen_byte(x);
                  sum += int'(x);
               end
               if (kind == 5) sum += int'($urandom_range(1, 255));
               gen_byte(8'(sum));
            end
            6: begin
               gen_byte(8'hAA); gen_byte(8'h55); gen_byte(8'($urandom));
               gen_byte(8'($urandom_range(MAXL + 1, 255)));
            end
            7: begin
               n = int'($urandom_range(1, 4));
               for (int i = 0; i < n; i++) gen_byte(($urandom_range(0, 1) == 0) ? 8'hAA : 8'($urandom));
            end
            8: begin
               gen_byte(8'hAA); gen_byte(8'h55); gen_byte(8'($urandom)); gen_byte(8'h03);
               gen_byte(8'($urandom));
               repeat (BTO + int'($urandom_range(0, 5))) stim.push_back({1'b0, 8'h00});
            end
            default: begin
               repeat (int'($urandom_range(LTO - 3, LTO + 20))) stim.push_back({1'b0, 8'h00});
            end
         endcase
      end

      do_reset();
      model_reset();
      for (int i = 0; i < stim.size(); i++) begin
         step(stim[i].v, stim[i].d);
         model_step(stim[i].v, stim[i].d);
         check($sformatf("rand[%0d]", i), snap(), pk(m_act, m_p0, m_p1, {m_fv, m_ce, m_fe}, m_ok));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
